seq_detect_fsm: RTL and testbench
=================================

Name: seq_detect_fsm

Overview:
- Parametrised successor to the team's fixed 4-state Mealy FSM: a serial pattern-detector FSM with generic pattern width and value.
- Selectable Mealy/Moore output timing, selectable overlap mode, input enable, synchronous clear and a saturating match counter.
- Sits on a 1-bit serial input stream; used as a reusable detector in the FSM exercise set.
- State encoding exposes the "bits matched so far" count, so the bench can observe progress directly.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, pattern value [PAT_W-1:0]; PATTERN[PAT_W-1] is the first bit expected on the stream.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = after a match the search restarts from empty.
- MOORE, 0, 0 = Mealy output (combinational from state and x); 1 = Moore output (decoded from registered state).
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  sample-enable; x is consumed only on edges where en=1.
- clear  input  1  synchronous clear of state and counter.
- x  input  1  serial data bit.
- y  output  1  match indication.
- state  output  SW=$clog2(PAT_W+1)  current state (number of pattern bits matched), range 0..PAT_W.
- match_cnt  output  CNT_W  number of matches detected since reset/clear, saturating.

Behaviour:
- Reset (reset_n=0, asynchronous): state=0, match_cnt=0, y=0 immediately, in both modes. Reset wins over everything.
- State k means the longest suffix of consumed bits that equals a prefix of PATTERN has length k.
  - State PAT_W is used only when MOORE=1 (post-match state); Mealy never enters it.
- Transition from k<PAT_W on input b:
  - If b == PATTERN[PAT_W-1-k], go to k+1.
  - Otherwise go to the longest j<=k such that the first j pattern bits equal the last j bits of (matched prefix, b). This is the KMP failure relation.
  - Table is elaboration-time constant, generated by a function; no runtime search.
- Match event: an enabled edge where k=PAT_W-1 and b matches the last pattern bit.
  - Mealy: next state = B if OVERLAP=1, else 0. B = length of the longest proper border of PATTERN (border of 1011 is 1).
  - Moore: next state = PAT_W.
  - From PAT_W, transitions are computed as from state B (OVERLAP=1) or from state 0 (OVERLAP=0).
- Output y:
  - Mealy: y = en & (state==PAT_W-1) & (x==PATTERN[0]) & ~clear. Asserted in the same cycle the final bit is presented, i.e. zero latency before the edge.
  - Moore: y = (state==PAT_W). Asserted for the cycle after the edge that sampled the final bit.
- en=0: state and match_cnt hold.
  - Mealy: y=0.
  - Moore: y follows the held state, so it stays high if the FSM is held in PAT_W.
- clear=1 (synchronous, priority over en): state->0, match_cnt->0. A match occurring on the same edge is not counted.
- match_cnt increments by 1 on every match event. At all-ones it holds; it never wraps.
- Reset mid-pattern discards partial progress; no match may be reported from pre-reset bits.
- Elaboration error if PAT_W is outside 2..16 or CNT_W<1.

Decomposition:
- Package seq_detect_pkg:
  - clog2 helper.
  - Constant function next_state_tbl(PATTERN, PAT_W, k, b), returning the KMP transition.
  - Function border_len(PATTERN, PAT_W).
  - State-width localparam formula.
- Sub-module sat_counter (parameter W; inputs clk, reset_n, clear, inc; output cnt; saturating). Instantiated once for match_cnt.

Test Plan:
- Default params (1011, Mealy, overlap), en=1, x=1,0,1,1,0,1,1 -> y=1 combinationally during bits 4 and 7 only; match_cnt=2; state after bit 7 = 1.
- OVERLAP=0, same stream -> y=1 during bit 4 only; match_cnt=1; state after bit 7 = 1.
- MOORE=1, same stream with overlap -> state=4 and y=1 in the cycle after bits 4 and 7; y=0 elsewhere; match_cnt=2.
- x=1,0 then en=0 for 3 cycles with x=0, then en=1 with x=1,1 -> state holds at 2 while disabled; match on last bit; match_cnt=1.
- CNT_W=2, stream 1011 repeated 5 times -> match_cnt = 1,2,3,3,3 (saturates).
- x=1,0,1, then reset_n pulsed low mid-cycle, then x=1 -> state=0 and y=0 asynchronously; after the next bit state=1; no match. Repeat the sequence using clear=1 -> identical result.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared helpers for the serial pattern detector: width math and the
// elaboration-time KMP transition / border functions.
package seq_detect_pkg;

    localparam int MAX_PAT_W = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // State counts 0..PAT_W matched bits, so it needs PAT_W+1 codes.
    function automatic int state_w(input int pat_w);
        return clog2(pat_w + 1);
    endfunction

    localparam int MAX_SW = state_w(MAX_PAT_W);

    // Longest proper border: prefix of length j equal to suffix of length j.
    function automatic int border_len(
        input logic [MAX_PAT_W-1:0] pat,
        input int                   w
    );
        for (int j = w - 1; j >= 1; j--) begin
            bit ok;
            ok = 1'b1;
            for (int i = 0; i < j; i++)
                if (pat[w-1-i] != pat[j-1-i]) ok = 1'b0;
            if (ok) return j;
        end
        return 0;
    endfunction

    // Next matched length after seeing bit b with k bits already matched.
    function automatic int next_state_tbl(
        input logic [MAX_PAT_W-1:0] pat,
        input int                   w,
        input int                   k,
        input logic                 b
    );
        logic [MAX_PAT_W:0] s;
        if (b == pat[w-1-k]) return k + 1;
        s = '0;
        for (int i = 0; i < k; i++) s[i] = pat[w-1-i];
        s[k] = b;
        for (int j = k; j >= 1; j--) begin
            bit ok;
            ok = 1'b1;
            for (int i = 0; i < j; i++)
                if (s[k+1-j+i] != pat[w-1-i]) ok = 1'b0;
            if (ok) return j;
        end
        return 0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/seq_detect_fsm.sv
// Generic serial pattern detector: KMP transition table, Mealy or Moore
// output, optional overlap, and a saturating match counter.
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MOORE   = 1'b0,
    parameter int               CNT_W   = 8,
    localparam int              SW      = state_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic             x,
    output logic             y,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_cnt
);

    if (PAT_W < 2 || PAT_W > MAX_PAT_W || CNT_W < 1) begin : g_bad_param
        $error("seq_detect_fsm: PAT_W must be 2..16 and CNT_W >= 1");
    end

    localparam logic [MAX_PAT_W-1:0] PAT = MAX_PAT_W'(PATTERN);
    localparam int BORDER = border_len(PAT, PAT_W);

    localparam logic [SW-1:0] ST_FULL    = SW'(PAT_W);
    localparam logic [SW-1:0] ST_LAST    = SW'(PAT_W - 1);
    localparam logic [SW-1:0] ST_RESTART = OVERLAP ? SW'(BORDER) : '0;

    logic [(PAT_W+1)*SW-1:0] tbl0;
    logic [(PAT_W+1)*SW-1:0] tbl1;

    // Row PAT_W (Moore post-match) behaves like the restart state.
    for (genvar k = 0; k <= PAT_W; k++) begin : g_tbl
        localparam int SRC = (k == PAT_W) ? (OVERLAP ? BORDER : 0) : k;
        localparam logic [SW-1:0] N0 =
            SW'(next_state_tbl(PAT, PAT_W, SRC, 1'b0));
        localparam logic [SW-1:0] N1 =
            SW'(next_state_tbl(PAT, PAT_W, SRC, 1'b1));
        assign tbl0[k*SW +: SW] = N0;
        assign tbl1[k*SW +: SW] = N1;
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW-1:0] raw;
    logic          hit;

    always_comb begin
        raw = x ? tbl1[state_q*SW +: SW] : tbl0[state_q*SW +: SW];
        hit = en & (raw == ST_FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= '0;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = '0;
        else if (en)
            state_d = (hit && !MOORE) ? ST_RESTART : raw;
    end

    always_comb begin
        y = 1'b0;
        if (MOORE)
            y = (state_q == ST_FULL);
        else
            y = en & (state_q == ST_LAST) & (x == PATTERN[0]) & ~clear;
    end

    assign state = state_q;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (hit),
        .cnt     (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: five configurations on one shared stream,
// checked by vector table, hand sequences and a suffix/prefix model.
module tb_seq_detect_fsm;

    localparam int ND = 5;
    localparam int P_W [ND]  = '{4, 4, 4, 4, 6};
    localparam int P_PAT[ND] = '{11, 11, 11, 11, 54};
    localparam bit P_OV [ND] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam bit P_MO [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam int P_CW [ND] = '{8, 8, 8, 2, 3};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic x = 1'b0;

    logic       y0, y1, y2, y3, y4;
    logic [2:0] st0, st1, st2, st3, st4;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;
    logic [2:0] c4;

    always #5 clk = ~clk;

    seq_detect_fsm u_d0 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .y(y0), .state(st0), .match_cnt(c0)
    );

    seq_detect_fsm #(.OVERLAP(1'b0)) u_d1 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .y(y1), .state(st1), .match_cnt(c1)
    );

    seq_detect_fsm #(.MOORE(1'b1)) u_d2 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .y(y2), .state(st2), .match_cnt(c2)
    );

    seq_detect_fsm #(.CNT_W(2)) u_d3 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .y(y3), .state(st3), .match_cnt(c3)
    );

    seq_detect_fsm #(
        .PAT_W(6), .PATTERN(6'b110110), .OVERLAP(1'b0),
        .MOORE(1'b1), .CNT_W(3)
    ) u_d4 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x(x),
        .y(y4), .state(st4), .match_cnt(c4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int act_y(input int d);
        case (d)
            0: return int'(y0);
            1: return int'(y1);
            2: return int'(y2);
            3: return int'(y3);
            default: return int'(y4);
        endcase
    endfunction

    function automatic int act_st(input int d);
        case (d)
            0: return int'(st0);
            1: return int'(st1);
            2: return int'(st2);
            3: return int'(st3);
            default: return int'(st4);
        endcase
    endfunction

    function automatic int act_cnt(input int d);
        case (d)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            3: return int'(c3);
            default: return int'(c4);
        endcase
    endfunction

    // Model: recent consumed bits (newest at bit 0) since the last restart.
    int hb  [ND];
    int hl  [ND];
    bit post[ND];
    int cnt [ND];

    function automatic bit pfx(input int d, input int h, input int len,
                               input int j);
        int m;
        if (j > len) return 1'b0;
        m = (1 << j) - 1;
        return (h & m) == ((P_PAT[d] >> (P_W[d] - j)) & m);
    endfunction

    function automatic int exp_state(input int d);
        if (P_MO[d] && post[d]) return P_W[d];
        for (int j = P_W[d] - 1; j >= 1; j--)
            if (pfx(d, hb[d], hl[d], j)) return j;
        return 0;
    endfunction

    function automatic bit hit(input int d, input bit b);
        return pfx(d, (hb[d] << 1) | int'(b), hl[d] + 1, P_W[d]);
    endfunction

    function automatic int exp_y(input int d);
        if (P_MO[d]) return int'(post[d]);
        return int'(en && !clear && hit(d, x));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            hb[d] = 0; hl[d] = 0; post[d] = 1'b0; cnt[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            if (clear) begin
                hb[d] = 0; hl[d] = 0; post[d] = 1'b0; cnt[d] = 0;
            end else if (en) begin
                bit m;
                m = hit(d, x);
                hb[d] = ((hb[d] << 1) | int'(x)) & 16'hFFFF;
                if (hl[d] < 16) hl[d]++;
                if (m && cnt[d] < (1 << P_CW[d]) - 1) cnt[d]++;
                if (m && !P_OV[d]) begin
                    hb[d] = 0; hl[d] = 0;
                end
                post[d] = m;
            end
        end
    endtask

    task automatic drive(input bit e, input bit c, input bit b);
        @(negedge clk);
        en = e; clear = c; x = b;
        #1;
    endtask

    task automatic check_y();
        for (int d = 0; d < ND; d++)
            chk($sformatf("model_y[d%0d]", d), act_y(d), exp_y(d));
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("model_state[d%0d]", d), act_st(d), exp_state(d));
            chk($sformatf("model_cnt[d%0d]", d), act_cnt(d), cnt[d]);
        end
    endtask

    task automatic step(input bit e, input bit c, input bit b);
        drive(e, c, b);
        check_y();
        clock_edge();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        en = 1'b0; clear = 1'b0; x = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_state[d%0d]", d), act_st(d), 0);
            chk($sformatf("rst_y[d%0d]", d), act_y(d), 0);
            chk($sformatf("rst_cnt[d%0d]", d), act_cnt(d), 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit en; bit clr; bit x;
        bit y0; bit y1; bit y2;
        int s0; int s1; int s2;
    } vec_t;

    vec_t vt[10];
    int   sat_exp[5] = '{1, 2, 3, 3, 3};
    int   tst[4] = '{1, 0, 1, 1};

    initial begin
        // en clr x | y: mealy, no-overlap, moore | state after edge
        vt[0] = '{1, 0, 1, 0, 0, 0, 1, 1, 1};
        vt[1] = '{1, 0, 0, 0, 0, 0, 2, 2, 2};
        vt[2] = '{1, 0, 1, 0, 0, 0, 3, 3, 3};
        vt[3] = '{1, 0, 1, 1, 1, 0, 1, 0, 4};
        vt[4] = '{1, 0, 0, 0, 0, 1, 2, 0, 2};
        vt[5] = '{1, 0, 1, 0, 0, 0, 3, 1, 3};
        vt[6] = '{1, 0, 1, 1, 0, 0, 1, 1, 4};
        vt[7] = '{0, 0, 0, 0, 0, 1, 1, 1, 4};
        vt[8] = '{1, 0, 0, 0, 0, 1, 2, 2, 2};
        vt[9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};

        #2;
        apply_reset();

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].en, vt[i].clr, vt[i].x);
            chk($sformatf("vec%0d_y0", i), int'(y0), int'(vt[i].y0));
            chk($sformatf("vec%0d_y1", i), int'(y1), int'(vt[i].y1));
            chk($sformatf("vec%0d_y2", i), int'(y2), int'(vt[i].y2));
            check_y();
            clock_edge();
            chk($sformatf("vec%0d_s0", i), int'(st0), vt[i].s0);
            chk($sformatf("vec%0d_s1", i), int'(st1), vt[i].s1);
            chk($sformatf("vec%0d_s2", i), int'(st2), vt[i].s2);
            if (i == 8) begin
                chk("vec_cnt_mealy", int'(c0), 2);
                chk("vec_cnt_noovl", int'(c1), 1);
                chk("vec_cnt_moore", int'(c2), 2);
            end
        end

        // Enable hold with a partial match in flight
        apply_reset();
        step(1, 0, 1);
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            chk("hold_state", int'(st0), 2);
        end
        step(1, 0, 1);
        drive(1, 0, 1);
        chk("hold_last_y", int'(y0), 1);
        check_y();
        clock_edge();
        chk("hold_cnt", int'(c0), 1);

        // Counter saturation on a 2-bit counter
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) step(1, 0, tst[i][0]);
            chk($sformatf("sat_rep%0d", r), int'(c3), sat_exp[r]);
        end

        // Asynchronous reset mid-pattern
        apply_reset();
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        @(negedge clk);
        en = 1'b0; x = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("async_state", int'(st0), 0);
        chk("async_y_mealy", int'(y0), 0);
        chk("async_y_moore", int'(y2), 0);
        model_reset();
        #1 reset_n = 1'b1;
        clock_edge();
        drive(1, 0, 1);
        chk("async_next_y", int'(y0), 0);
        check_y();
        clock_edge();
        chk("async_next_state", int'(st0), 1);
        chk("async_next_cnt", int'(c0), 0);

        // Same sequence using synchronous clear
        apply_reset();
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        drive(1, 1, 1);
        chk("clear_y", int'(y0), 0);
        check_y();
        clock_edge();
        chk("clear_state", int'(st0), 0);
        drive(1, 0, 1);
        chk("clear_next_y", int'(y0), 0);
        check_y();
        clock_edge();
        chk("clear_next_state", int'(st0), 1);
        chk("clear_next_cnt", int'(c0), 0);

        // Randomized stream against the model
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 59) == 0,
                 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
